// File: rtl/div_sequencer.sv
// Iterative radix-2 restoring divider controller for the execute stage.
// Captures operands on a divide start, stalls the pipeline while it runs one
// quotient bit per cycle, then presents the quotient for a single DONE cycle.
module div_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             DivStartE,
  input  logic             DivSignedE,
  input  logic [WIDTH-1:0] RnE,
  input  logic [WIDTH-1:0] RmE,
  input  logic             KillE,
  output logic             StallDivE,
  output logic             DivDoneE,
  output logic [WIDTH-1:0] QuotE,
  output logic             DivBusy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d;

  logic             start_ok;
  logic [WIDTH-1:0] rn_abs, rm_abs, result;
  logic [WIDTH:0]   rem_sh, diff;

  // Datapath helpers: operand magnitudes, one trial-subtract step, signed fix-up
  always_comb begin
    start_ok = (state_q == IDLE) & DivStartE & ~KillE;
    rn_abs   = (DivSignedE & RnE[WIDTH-1]) ? -RnE : RnE;
    rm_abs   = (DivSignedE & RmE[WIDTH-1]) ? -RmE : RmE;
    rem_sh   = {rem_q, dq_q[WIDTH-1]};
    // rem < divisor, so bit WIDTH of the difference is a reliable borrow flag
    diff     = rem_sh - {1'b0, dvsr_q};
    // WIDTH-bit negate wraps 0x80..0 / -1 back to 0x80..0 on its own
    result   = qneg_q ? -dq_q : dq_q;
  end

  // Next-state logic for the FSM and the iteration registers
  always_comb begin
    state_d = state_q;
    dq_d    = dq_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    if (KillE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (DivStartE) begin
            // A zero divisor loads a zero quotient and skips straight to DONE
            dq_d    = (RmE == '0) ? '0 : rn_abs;
            dvsr_d  = rm_abs;
            rem_d   = '0;
            cnt_d   = CW'(WIDTH);
            qneg_d  = DivSignedE & (RnE[WIDTH-1] ^ RmE[WIDTH-1]);
            state_d = (RmE == '0) ? DONE : CALC;
          end
        end
        CALC: begin
          if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            dq_d  = {dq_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = rem_sh[WIDTH-1:0];
            dq_d  = {dq_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = DONE;
          end
        end
        DONE: begin
          // A start seen here is the same instruction; never relaunch
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Outputs; QuotE shows the fresh result in DONE and the held copy otherwise
  always_comb begin
    StallDivE = start_ok | (state_q == CALC);
    DivDoneE  = (state_q == DONE) & ~KillE;
    DivBusy   = (state_q != IDLE);
    QuotE     = DivDoneE ? result : quot_q;
    quot_d    = DivDoneE ? result : quot_q;
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dq_q    <= '0;
      rem_q   <= '0;
      dvsr_q  <= '0;
      quot_q  <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dq_q    <= dq_d;
      rem_q   <= rem_d;
      dvsr_q  <= dvsr_d;
      quot_q  <= quot_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: expected quotients are pushed to a
// scoreboard at start and popped when DivDoneE is observed.
module tb_div_sequencer;

  localparam int W = 32;

  logic          clk;
  logic          reset;
  logic          DivStartE;
  logic          DivSignedE;
  logic [W-1:0]  RnE;
  logic [W-1:0]  RmE;
  logic          KillE;
  logic          StallDivE;
  logic          DivDoneE;
  logic [W-1:0]  QuotE;
  logic          DivBusy;

  int            n_cmp;
  int            n_err;
  int            cyc;
  logic [W-1:0]  sb[$];
  logic [W-1:0]  last_q;

  div_sequencer #(.WIDTH(W), .CW(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .DivStartE (DivStartE),
    .DivSignedE(DivSignedE),
    .RnE       (RnE),
    .RmE       (RmE),
    .KillE     (KillE),
    .StallDivE (StallDivE),
    .DivDoneE  (DivDoneE),
    .QuotE     (QuotE),
    .DivBusy   (DivBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one divide starting at the current cycle, holding start through the
  // stall as a frozen pipeline would, and check stall/done timing every cycle.
  task automatic run_div(input string tag, input logic sgn, input logic [W-1:0] rn,
                         input logic [W-1:0] rm, input logic [W-1:0] exp,
                         input bit idle_chk, output int done_cyc);
    int lat;
    lat        = (rm == '0) ? 1 : W + 1;
    done_cyc   = -1;
    DivStartE  = 1'b1;
    DivSignedE = sgn;
    RnE        = rn;
    RmE        = rm;
    sb.push_back(exp);
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      check({tag, "/stall"}, W'(StallDivE), W'(c < lat));
      check({tag, "/done"}, W'(DivDoneE), W'(c == lat));
      if (DivDoneE) begin
        done_cyc = cyc;
        if (sb.size() == 0) begin
          check({tag, "/unexpected_done"}, W'(1), W'(0));
        end else begin
          check({tag, "/quot"}, QuotE, sb.pop_front());
        end
      end
      @(posedge clk);
      #1;
      if (c == lat) DivStartE = 1'b0;
    end
    if (sb.size() != 0) begin
      check({tag, "/missing_done"}, W'(sb.size()), W'(0));
      sb.delete();
    end
    last_q = exp;
    if (idle_chk) begin
      @(negedge clk);
      check({tag, "/no_relaunch"}, W'(DivBusy), W'(0));
      check({tag, "/done_once"}, W'(DivDoneE), W'(0));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int d0, d1;
    n_cmp      = 0;
    n_err      = 0;
    cyc        = 0;
    last_q     = '0;
    reset      = 1'b1;
    DivStartE  = 1'b0;
    DivSignedE = 1'b0;
    RnE        = '0;
    RmE        = '0;
    KillE      = 1'b0;

    // Reset values
    #1;
    check("rst/stall", W'(StallDivE), W'(0));
    check("rst/done", W'(DivDoneE), W'(0));
    check("rst/busy", W'(DivBusy), W'(0));
    check("rst/quot", QuotE, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Unsigned and signed quotients
    run_div("udiv_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 1'b1, d0);
    run_div("udiv_big_7", 1'b0, 32'hFFFF_FF9C, 32'd7, 32'h2492_4916, 1'b1, d0);
    run_div("sdiv_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b1, d0);
    run_div("sdiv_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b1, d0);
    run_div("sdiv_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 1'b1, d0);
    run_div("sdiv_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, d0);

    // Abort at cycle 10 of a running divide
    DivStartE  = 1'b1;
    DivSignedE = 1'b0;
    RnE        = 32'd100;
    RmE        = 32'd7;
    for (int c = 0; c <= 10; c++) begin
      if (c == 10) KillE = 1'b1;
      @(negedge clk);
      check("kill/stall", W'(StallDivE), W'(1));
      check("kill/done", W'(DivDoneE), W'(0));
      @(posedge clk);
      #1;
    end
    KillE     = 1'b0;
    DivStartE = 1'b0;
    @(negedge clk);
    check("kill/busy", W'(DivBusy), W'(0));
    check("kill/done_after", W'(DivDoneE), W'(0));
    check("kill/quot_held", QuotE, last_q);
    @(posedge clk);
    #1;
    run_div("after_kill", 1'b0, 32'd1000, 32'd3, 32'd333, 1'b1, d0);

    // Asynchronous reset between edges mid-CALC
    DivStartE  = 1'b1;
    DivSignedE = 1'b0;
    RnE        = 32'd77;
    RmE        = 32'd7;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("arst/stall_pre", W'(StallDivE), W'(1));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #2;
    reset     = 1'b1;
    DivStartE = 1'b0;
    #1;
    check("arst/busy", W'(DivBusy), W'(0));
    check("arst/stall", W'(StallDivE), W'(0));
    check("arst/quot", QuotE, '0);
    last_q = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_div("udiv_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b1, d0);

    // Divide by zero
    run_div("udiv_5_0", 1'b0, 32'd5, 32'd0, 32'd0, 1'b1, d0);
    run_div("sdiv_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'd0, 1'b1, d0);

    // Back-to-back: second start in the cycle right after DONE
    run_div("b2b_50_5", 1'b0, 32'd50, 32'd5, 32'd10, 1'b0, d0);
    run_div("b2b_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 1'b1, d1);
    check("b2b/spacing", W'(d1 - d0), W'(34));

    check("sb/empty", W'(sb.size()), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
